// File: rtl/collapse_queue.sv
// Collapsing multi-entry queue: head at entry 0, pops collapse the remainder toward 0, pushes append at the tail.
// Optional synchronous flush port enabled by defining COLLAPSE_QUEUE_FLUSH_EN.

module block_shift #(
  parameter int unsigned ELMS     = 8,
  parameter int unsigned DATA     = 8,
  parameter int unsigned SHAMT    = 4,
  parameter bit          ROTATE   = 1'b0,
  parameter bit          TO_RIGHT = 1'b1
) (
  input  logic [ELMS-1:0][DATA-1:0] din,
  input  logic [SHAMT-1:0]          shamt,
  output logic [ELMS-1:0][DATA-1:0] dout
);

  // TO_RIGHT moves data toward index 0: dout[i] = din[i+shamt].
  function automatic logic src_match(input int unsigned i, input int unsigned j,
                                     input logic [SHAMT-1:0] s);
    int unsigned sa;
    int unsigned hi;
    int unsigned lo;
    sa = 32'(s);
    hi = TO_RIGHT ? j : i;
    lo = TO_RIGHT ? i : j;
    if (ROTATE) return hi == ((lo + sa) % ELMS);
    else        return hi == (lo + sa);
  endfunction

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < ELMS; i++) begin
      for (int unsigned j = 0; j < ELMS; j++) begin
        if (src_match(i, j, shamt)) dout[i] = din[j];
      end
    end
  end

endmodule

module collapse_queue #(
  parameter  int unsigned ELMS    = 8,
  parameter  int unsigned DATA    = 8,
  parameter  int unsigned IN_ELMS = 4,
  localparam int unsigned SHAMT   = $clog2(ELMS + 1),
  localparam int unsigned IN_CNT  = $clog2(IN_ELMS + 1)
) (
  input  logic                         clk,
  input  logic                         reset_,
`ifdef COLLAPSE_QUEUE_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [IN_CNT-1:0]            push_cnt,
  input  logic [IN_ELMS-1:0][DATA-1:0] push_data,
  input  logic [SHAMT-1:0]             pop_cnt,
  output logic [ELMS-1:0][DATA-1:0]    out,
  output logic [ELMS-1:0]              valid,
  output logic [SHAMT-1:0]             count,
  output logic [SHAMT-1:0]             free_cnt,
  output logic                         ovf,
  output logic                         udf
);

  localparam int unsigned    CW     = SHAMT + 1;
  localparam logic [CW-1:0]  ELMS_W = CW'(ELMS);

  logic [CW-1:0] cnt_w;
  logic [CW-1:0] pop_w;
  logic [CW-1:0] push_w;
  logic [CW-1:0] pop_eff;
  logic [CW-1:0] avail;
  logic [CW-1:0] push_eff;
  logic [CW-1:0] base;
  logic [CW-1:0] new_cnt;
  logic          under;
  logic          reject;

  logic [ELMS-1:0][DATA-1:0] shifted;
  logic [ELMS-1:0][DATA-1:0] next_out;
  logic [ELMS-1:0]           next_valid;

  // One extra bit keeps count+push from wrapping.
  always_comb begin
    cnt_w    = CW'(count);
    pop_w    = CW'(pop_cnt);
    push_w   = CW'(push_cnt);
    under    = pop_w > cnt_w;
    pop_eff  = under ? cnt_w : pop_w;
    avail    = ELMS_W - cnt_w + pop_eff;
    reject   = push_w > avail;
    push_eff = reject ? '0 : push_w;
    base     = cnt_w - pop_eff;
    new_cnt  = base + push_eff;
  end

  block_shift #(
    .ELMS     (ELMS),
    .DATA     (DATA),
    .SHAMT    (SHAMT),
    .ROTATE   (1'b0),
    .TO_RIGHT (1'b1)
  ) u_shift (
    .din   (out),
    .shamt (pop_eff[SHAMT-1:0]),
    .dout  (shifted)
  );

  always_comb begin
    next_out   = shifted;
    next_valid = '0;
    for (int unsigned k = 0; k < IN_ELMS; k++) begin
      if (CW'(k) < push_eff) begin
        for (int unsigned i = 0; i < ELMS; i++) begin
          if (CW'(i) == base + CW'(k)) next_out[i] = push_data[k];
        end
      end
    end
    // Scrub everything above the new tail so no stale data is ever visible.
    for (int unsigned i = 0; i < ELMS; i++) begin
      next_valid[i] = CW'(i) < new_cnt;
      if (!next_valid[i]) next_out[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out      <= '0;
      valid    <= '0;
      count    <= '0;
      free_cnt <= SHAMT'(ELMS);
      ovf      <= 1'b0;
      udf      <= 1'b0;
`ifdef COLLAPSE_QUEUE_FLUSH_EN
    end else if (flush) begin
      out      <= '0;
      valid    <= '0;
      count    <= '0;
      free_cnt <= SHAMT'(ELMS);
      ovf      <= 1'b0;
      udf      <= 1'b0;
`endif
    end else begin
      out      <= next_out;
      valid    <= next_valid;
      count    <= new_cnt[SHAMT-1:0];
      free_cnt <= SHAMT'(ELMS_W - new_cnt);
      if (reject) ovf <= 1'b1;
      if (under)  udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collapse_queue.sv
// Scoreboard bench for collapse_queue (default parameters ELMS=8, DATA=8, IN_ELMS=4).
// Flush scenario is exercised when COLLAPSE_QUEUE_FLUSH_EN is defined.

module tb_collapse_queue;

  logic            clk = 1'b0;
  logic            reset_;
  logic [2:0]      push_cnt;
  logic [3:0][7:0] push_data;
  logic [3:0]      pop_cnt;
  logic [7:0][7:0] out;
  logic [7:0]      valid;
  logic [3:0]      count;
  logic [3:0]      free_cnt;
  logic            ovf;
  logic            udf;
`ifdef COLLAPSE_QUEUE_FLUSH_EN
  logic            flush;
`endif

  always #5 clk = ~clk;

  collapse_queue #(.ELMS(8), .DATA(8), .IN_ELMS(4)) dut (
    .clk       (clk),
    .reset_    (reset_),
`ifdef COLLAPSE_QUEUE_FLUSH_EN
    .flush     (flush),
`endif
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .out       (out),
    .valid     (valid),
    .count     (count),
    .free_cnt  (free_cnt),
    .ovf       (ovf),
    .udf       (udf)
  );

  typedef struct packed {
    logic [63:0] out;
    logic [7:0]  valid;
    logic [3:0]  count;
    logic [3:0]  free;
    logic        ovf;
    logic        udf;
  } snap_t;

  localparam snap_t RESET_SNAP = '{out: 64'h0, valid: 8'h00, count: 4'd0, free: 4'd8, ovf: 1'b0, udf: 1'b0};

  snap_t        obs;
  snap_t        e;
  snap_t        sb[$];
  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_udf;
  int           vectors;
  int           miscompares;

  assign obs = {out, valid, count, free_cnt, ovf, udf};

  function automatic snap_t model_snap();
    snap_t s;
    int    n;
    n       = mq.size();
    s.out   = '0;
    for (int i = 0; i < n; i++) s.out[i*8 +: 8] = mq[i];
    s.valid = 8'((1 << n) - 1);
    s.count = 4'(n);
    s.free  = 4'(8 - n);
    s.ovf   = m_ovf;
    s.udf   = m_udf;
    return s;
  endfunction

  // Update the reference queue, queue the expected state, then clock the DUT once.
  task automatic drive(input int pc, input logic [31:0] d, input int pp);
    int pe;
    if (pp > mq.size()) begin
      m_udf = 1'b1;
      pe    = mq.size();
    end else begin
      pe = pp;
    end
    repeat (pe) void'(mq.pop_front());
    if (pc <= 8 - mq.size()) begin
      for (int k = 0; k < pc; k++) mq.push_back(d[k*8 +: 8]);
    end else begin
      m_ovf = 1'b1;
    end
    sb.push_back(model_snap());
    push_cnt  = 3'(pc);
    push_data = d;
    pop_cnt   = 4'(pp);
    @(posedge clk);
    #1;
    push_cnt = '0;
    pop_cnt  = '0;
  endtask

  task automatic apply_reset();
    reset_ = 1'b0;
    mq.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (obs !== RESET_SNAP) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h", obs, RESET_SNAP);
    end
    apply_reset();
    drive(0, 32'h0, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || obs !== RESET_SNAP) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_push_basic();
    drive(3, 32'h00A2A1A0, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL push_basic: got %h want %h", obs, e);
    end
    vectors++;
    if ({out[2], out[1], out[0], valid, count, free_cnt} !== {24'hA2A1A0, 8'h07, 4'd3, 4'd5}) begin
      miscompares++;
      $display("FAIL push_basic_fields: got %h/%h/%0d/%0d want a2a1a0/07/3/5",
               {out[2], out[1], out[0]}, valid, count, free_cnt);
    end
  endtask

  task automatic test_collapse();
    drive(4, 32'hB3B2B1B0, 2);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL collapse: got %h want %h", obs, e);
    end
    vectors++;
    if ({out, valid, count} !== {24'h0, 40'hB3B2B1B0A2, 8'h1F, 4'd5}) begin
      miscompares++;
      $display("FAIL collapse_fields: got %h/%h/%0d want 000000b3b2b1b0a2/1f/5", out, valid, count);
    end
  endtask

  task automatic test_overflow();
    drive(3, 32'h00C2C1C0, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || count !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_full: got %h want %h", obs, e);
    end
    drive(1, 32'h000000DD, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL push_full_reject: got %h want %h", obs, e);
    end
    drive(1, 32'h000000EE, 1);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || out[7] !== 8'hEE || count !== 4'd8) begin
      miscompares++;
      $display("FAIL push_pop_full: got %h want %h", obs, e);
    end
    drive(2, 32'h0000F2F1, 2);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || {out[7], out[6]} !== 16'hF2F1) begin
      miscompares++;
      $display("FAIL push2_pop2_full: got %h want %h", obs, e);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(2, 32'h0000F1F0, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL underflow_setup: got %h want %h", obs, e);
    end
    drive(0, 32'h0, 5);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || {out, valid, count, udf, ovf} !== {64'h0, 8'h00, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL over_pop: got %h want %h", obs, e);
    end
    drive(0, 32'h0, 1);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL pop_empty: got %h want %h", obs, e);
    end
  endtask

  task automatic test_hold();
    drive(3, 32'h00343332, 0);
    void'(sb.pop_front());
    for (int r = 0; r < 2; r++) begin
      push_data = 32'hDEADBEEF;
      drive(0, 32'hDEADBEEF, 0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL hold_%0d: got %h want %h", r, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      drive(int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 9)));
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", n, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4, 32'h13121110, 0);
    void'(sb.pop_front());
    drive(2, 32'h00001514, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || count !== 4'd6) begin
      miscompares++;
      $display("FAIL async_setup: got %h want %h", obs, e);
    end
    #3;
    reset_ = 1'b0;
    #1;
    vectors++;
    if (obs !== RESET_SNAP) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", obs, RESET_SNAP);
    end
    apply_reset();
  endtask

`ifdef COLLAPSE_QUEUE_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    drive(0, 32'h0, 1);
    void'(sb.pop_front());
    drive(4, 32'h23222120, 0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || count !== 4'd4 || udf !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup: got %h want %h", obs, e);
    end
    flush     = 1'b1;
    push_cnt  = 3'd2;
    push_data = 32'h00002524;
    pop_cnt   = 4'd3;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    push_cnt = '0;
    pop_cnt  = '0;
    vectors++;
    if (obs !== RESET_SNAP) begin
      miscompares++;
      $display("FAIL flush_clear: got %h want %h", obs, RESET_SNAP);
    end
  endtask
`endif

  initial begin
    reset_      = 1'b0;
    push_cnt    = '0;
    push_data   = '0;
    pop_cnt     = '0;
    vectors     = 0;
    miscompares = 0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
`ifdef COLLAPSE_QUEUE_FLUSH_EN
    flush       = 1'b0;
`endif
    test_reset();
    test_push_basic();
    test_collapse();
    test_overflow();
    test_underflow();
    test_hold();
    test_back_to_back();
    test_async_reset();
`ifdef COLLAPSE_QUEUE_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/collapse_queue.md
Name: collapse_queue

Overview:
- Multi-entry collapsing queue holding up to ELMS elements of DATA bits each.
- Head is always at entry 0. Each cycle the consumer retires 0..ELMS head entries and the producer appends 0..IN_ELMS entries at the tail.
- The remaining entries collapse toward entry 0 through a block_shift instance (logical shift toward index 0, no rotate).
- Sits directly upstream of issue/select logic. It is the block that generates the shift amount and element vector consumed by the block shifter.

Parameters:
- ELMS, 8, number of queue entries
- DATA, 8, bits per element
- IN_ELMS, 4, max elements pushed per cycle (1..ELMS)
- SHAMT, $clog2(ELMS+1), width of counts/shift amount (constant, not overridden)
- IN_CNT, $clog2(IN_ELMS+1), width of push count (constant)

Ports:
- clk  in  1  clock, rising edge
- reset_  in  1  asynchronous active-low reset
- push_cnt  in  IN_CNT  number of valid elements in push_data, packed from index 0
- push_data  in  IN_ELMS x DATA  elements to append; [0] is oldest
- pop_cnt  in  SHAMT  number of head entries retired this cycle
- out  out  ELMS x DATA  registered queue contents; [0] is head
- valid  out  ELMS  registered thermometer mask of occupied entries
- count  out  SHAMT  registered occupancy, 0..ELMS
- free_cnt  out  SHAMT  registered ELMS-count
- ovf  out  1  sticky push-rejected flag
- udf  out  1  sticky over-pop flag

Behaviour:
- Reset (reset_ low, asynchronous): out all zero, valid=0, count=0, free_cnt=ELMS, ovf=0, udf=0. Reset asserted mid-operation discards all contents immediately.
- Per cycle, computed combinationally from registered state:
  - pop_eff = min(pop_cnt, count). If pop_cnt > count, set udf.
  - avail = ELMS - count + pop_eff.
  - If push_cnt <= avail, the push is accepted: push_eff = push_cnt.
  - Otherwise the whole push is rejected (no partial push): push_eff = 0 and ovf is set.
- Shift stage: block_shift with ROTATE disabled and TO_RIGHT enabled, shamt = pop_eff. Entry i takes entry i+pop_eff; vacated top entries are zero.
- Append stage: for k < push_eff, shifted entry (count-pop_eff+k) takes push_data[k].
- Entries at index >= new count are forced to zero, so out never carries stale data.
- Next state: count' = count - pop_eff + push_eff; valid' = (1<<count')-1; free_cnt' = ELMS-count'.
- All outputs update on the rising edge. Latency is 1 cycle: data pushed in cycle N is visible on out in cycle N+1.
- Simultaneous push and pop is legal, including at full: count=ELMS, pop 2, push 2 is accepted.
- Push to a full queue with pop 0 is rejected. Pop from an empty queue sets udf, with count staying 0.
- push_cnt=0 and pop_cnt=0 hold state unchanged.
- ovf and udf stay set until reset.
- Arithmetic is done in SHAMT+1 bits internally to avoid wrap on count+push.
- No internal state machine beyond the count register. Storage is ELMS x DATA flops.

Optional Feature:
- Macro: COLLAPSE_QUEUE_FLUSH_EN.
- Defined: adds input port flush (1 bit), which acts as a synchronous clear.
  - When flush=1 at a clock edge, all outputs take their reset values on that edge, including clearing ovf and udf.
  - flush overrides any push and pop in the same cycle.
  - Push and pop occupancy checks in that cycle are ignored; no flags are set.
- Undefined: no flush port; contents clear only via reset_.

Test Plan:
- Reset then push_cnt=3 with data {A0,A1,A2}, pop 0 -> next cycle out[0..2]=A0,A1,A2, valid=8'h07, count=3, free_cnt=5.
- From count=3, pop_cnt=2 and push_cnt=4 with {B0..B3} -> out[0]=A2, out[1..4]=B0..B3, valid=8'h1F, count=5, out[5..7]=0.
- Fill to count=8, then push_cnt=1 with pop 0 -> push rejected, ovf=1, contents unchanged. Next cycle pop 1 with push 1 -> accepted, count=8, new element at out[7].
- From count=2, pop_cnt=5 -> udf=1, count=0, valid=0, out all zero.
- Mid-stream with count=6, assert reset_ low between clock edges -> outputs go to reset values immediately, without waiting for the next edge.
- With COLLAPSE_QUEUE_FLUSH_EN defined: count=4, flush=1 together with push_cnt=2 -> count=0, valid=0, ovf=0. Without the macro, the flush port is absent from elaboration.
